// File: rtl/sam_pkg.sv
// Shared constants, types and token classification for the SAM action sequencer.
package sam_pkg;

    localparam logic [7:0] ChS    = 8'h53;
    localparam logic [7:0] ChA    = 8'h41;
    localparam logic [7:0] ChM    = 8'h4d;
    localparam logic [7:0] ChDash = 8'h2d;
    localparam logic [7:0] ChDot  = 8'h2e;
    localparam logic [7:0] ChHash = 8'h23;
    localparam logic [7:0] ChX    = 8'h58;
    localparam logic [7:0] ChU    = 8'h55;
    localparam logic [7:0] Ch0    = 8'h30;
    localparam logic [7:0] Ch9    = 8'h39;

    localparam logic [1:0] UnitNone = 2'd0;
    localparam logic [1:0] UnitPu   = 2'd1;
    localparam logic [1:0] UnitFu   = 2'd2;
    localparam logic [1:0] UnitWu   = 2'd3;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrFraming = 2'd1;
    localparam logic [1:0] ErrUnit    = 2'd2;
    localparam logic [1:0] ErrToken   = 2'd3;

    // Tables are packed with entry 0 in the least-significant slice.
    localparam logic [44:0] DefUnitNodes = {5'd13, 5'd15, 5'd17,
                                            5'd20, 5'd22, 5'd25,
                                            5'd31, 5'd29, 5'd27};
    localparam logic [14:0] DefMuNodes   = {5'd7, 5'd8, 5'd9};
    localparam logic [14:0] DefSuNodes   = {5'd3, 5'd4, 5'd5};

    typedef logic [2:0][7:0] token_t;

    typedef enum logic [1:0] {TkSkip, TkMu, TkSu, TkBad} tok_kind_e;

    typedef struct packed {
        tok_kind_e  kind;
        logic [3:0] digit;
    } tok_info_t;

    typedef enum logic [1:0] {StIdle, StDispatch, StWait} seq_state_e;

    function automatic tok_info_t token_kind(input token_t tok);
        tok_info_t info;
        info.digit = 4'(tok[2] - Ch0);
        if (tok[0] == ChX && tok[1] == ChX && tok[2] == ChX) begin
            info.kind = TkSkip;
        end else if (tok[2] < Ch0 || tok[2] > Ch9 || tok[1] != ChU) begin
            info.kind = TkBad;
        end else if (tok[0] == ChM) begin
            info.kind = TkMu;
        end else if (tok[0] == ChS) begin
            info.kind = TkSu;
        end else begin
            info.kind = TkBad;
        end
        return info;
    endfunction

endpackage

// File: rtl/sam_action_sequencer_if.sv
// Byte-stream input and action handshake bundle of the SAM action sequencer.
interface sam_action_sequencer_if #(
    parameter int unsigned NODE_W = 5
);
    logic              rx_complete;
    logic [7:0]        rx_msg;
    logic [1:0]        unit_type;
    logic              task_complete;
    logic              abort;
    logic [NODE_W-1:0] pick_node;
    logic [NODE_W-1:0] place_node;
    logic [3:0]        slot;
    logic              action_valid;
    logic              busy;
    logic              seq_done;
    logic              msg_error;
    logic [1:0]        err_code;

    modport master (
        output rx_complete, rx_msg, unit_type, task_complete, abort,
        input  pick_node, place_node, slot, action_valid, busy, seq_done, msg_error, err_code
    );

    modport slave (
        input  rx_complete, rx_msg, unit_type, task_complete, abort,
        output pick_node, place_node, slot, action_valid, busy, seq_done, msg_error, err_code
    );
endinterface

// File: rtl/sam_frame_parser.sv
// Framing parser for "SAM-1.TTT-...-N.TTT-#": stores slot tokens, flags frame end or error.
module sam_frame_parser
    import sam_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     abort,
    input  logic                     rx_complete,
    input  logic [7:0]               rx_msg,
    output token_t [NUM_SLOTS-1:0]   tokens,
    output logic                     frame_ok,
    output logic                     frame_err
);

    typedef enum logic [3:0] {
        PsIdle, PsHdrA, PsHdrM, PsDash, PsIdx, PsDot, PsTok0, PsTok1, PsTok2, PsHash
    } pstate_e;

    localparam logic [3:0] LastCnt = 4'(NUM_SLOTS + 1);

    pstate_e                state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    token_t [NUM_SLOTS-1:0] tokens_q, tokens_d;
    logic [3:0]             wr_idx;
    logic                   mismatch;

    assign wr_idx = cnt_q - 4'd1;
    assign tokens = tokens_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tokens_d  = tokens_q;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        mismatch  = 1'b0;
        if (abort) begin
            state_d = PsIdle;
        end else if (enable && rx_complete) begin
            unique case (state_q)
                PsIdle: if (rx_msg == ChS) state_d = PsHdrA;
                PsHdrA: if (rx_msg == ChA) state_d = PsHdrM; else mismatch = 1'b1;
                PsHdrM: begin
                    if (rx_msg == ChM) begin
                        state_d = PsDash;
                        cnt_d   = 4'd1;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                PsDash: begin
                    if (rx_msg == ChDash) state_d = (cnt_q == LastCnt) ? PsHash : PsIdx;
                    else mismatch = 1'b1;
                end
                PsIdx: if (rx_msg == (Ch0 + {4'h0, cnt_q})) state_d = PsDot; else mismatch = 1'b1;
                PsDot: if (rx_msg == ChDot) state_d = PsTok0; else mismatch = 1'b1;
                PsTok0, PsTok1, PsTok2: begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (wr_idx == 4'(i)) begin
                            if (state_q == PsTok0) tokens_d[i][0] = rx_msg;
                            else if (state_q == PsTok1) tokens_d[i][1] = rx_msg;
                            else tokens_d[i][2] = rx_msg;
                        end
                    end
                    if (state_q == PsTok0) begin
                        state_d = PsTok1;
                    end else if (state_q == PsTok1) begin
                        state_d = PsTok2;
                    end else begin
                        state_d = PsDash;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                PsHash: begin
                    if (rx_msg == ChHash) begin
                        frame_ok = 1'b1;
                        state_d  = PsIdle;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                default: state_d = PsIdle;
            endcase
            // An unexpected 'S' is taken as the start of a fresh header.
            if (mismatch) begin
                frame_err = 1'b1;
                state_d   = (rx_msg == ChS) ? PsHdrA : PsIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PsIdle;
            cnt_q    <= 4'd0;
            tokens_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tokens_q <= tokens_d;
        end
    end

endmodule

// File: rtl/sam_action_sequencer.sv
// Parses SAM messages and dispatches each slot as a pick/place action with valid/complete handshake.
module sam_action_sequencer
    import sam_pkg::*;
#(
    parameter int unsigned                    NUM_SLOTS  = 3,
    parameter int unsigned                    NODE_W     = 5,
    parameter int unsigned                    NUM_DEST   = 3,
    parameter logic [3*NUM_SLOTS*NODE_W-1:0]  UNIT_NODES = DefUnitNodes,
    parameter logic [NUM_DEST*NODE_W-1:0]     MU_NODES   = DefMuNodes,
    parameter logic [NUM_DEST*NODE_W-1:0]     SU_NODES   = DefSuNodes
) (
    input logic                   clk,
    input logic                   rst,
    sam_action_sequencer_if.slave bus
);

    seq_state_e             state_q, state_d;
    logic [3:0]             slot_q, slot_d;
    logic [1:0]             unit_q, unit_d;
    logic [NODE_W-1:0]      pick_q, pick_d, place_q, place_d;
    logic                   av_q, av_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]             code_q, code_d;

    token_t [NUM_SLOTS-1:0] tokens;
    logic                   frame_ok, frame_err;
    token_t                 cur_tok;
    tok_info_t              info;
    logic                   dest_ok, last_slot;
    int unsigned            slot_idx, unit_idx, dest_idx;
    logic [NODE_W-1:0]      unit_node, mu_node, su_node;

    sam_frame_parser #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_parser (
        .clk         (clk),
        .rst         (rst),
        .enable      (state_q == StIdle),
        .abort       (bus.abort),
        .rx_complete (bus.rx_complete),
        .rx_msg      (bus.rx_msg),
        .tokens      (tokens),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err)
    );

    // Table lookups for the slot under evaluation; indices are clamped to stay in range.
    always_comb begin
        cur_tok  = '0;
        slot_idx = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == 4'(i + 1)) begin
                cur_tok  = tokens[i];
                slot_idx = i;
            end
        end
        info      = token_kind(cur_tok);
        dest_ok   = (info.digit >= 4'd1) && (info.digit <= 4'(NUM_DEST));
        dest_idx  = dest_ok ? int'(info.digit) - 1 : 0;
        unit_idx  = (unit_q == UnitNone) ? 0 : int'(unit_q) - 1;
        unit_node = UNIT_NODES[(unit_idx * NUM_SLOTS + slot_idx) * NODE_W +: NODE_W];
        mu_node   = MU_NODES[dest_idx * NODE_W +: NODE_W];
        su_node   = SU_NODES[dest_idx * NODE_W +: NODE_W];
        last_slot = (slot_q == 4'(NUM_SLOTS));
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unit_d  = unit_q;
        pick_d  = pick_q;
        place_d = place_q;
        av_d    = av_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        if (bus.abort) begin
            state_d = StIdle;
            av_d    = 1'b0;
            busy_d  = 1'b0;
            slot_d  = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_err) begin
                        err_d  = 1'b1;
                        code_d = ErrFraming;
                    end else if (frame_ok) begin
                        if (bus.unit_type == UnitNone) begin
                            err_d  = 1'b1;
                            code_d = ErrUnit;
                        end else begin
                            unit_d  = bus.unit_type;
                            busy_d  = 1'b1;
                            slot_d  = 4'd1;
                            state_d = StDispatch;
                        end
                    end
                end
                StDispatch: begin
                    if ((info.kind == TkMu || info.kind == TkSu) && dest_ok) begin
                        pick_d  = (info.kind == TkMu) ? unit_node : su_node;
                        place_d = (info.kind == TkMu) ? mu_node : unit_node;
                        av_d    = 1'b1;
                        state_d = StWait;
                    end else begin
                        if (info.kind != TkSkip) begin
                            err_d  = 1'b1;
                            code_d = ErrToken;
                        end
                        if (last_slot) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            slot_d  = 4'd0;
                        end else begin
                            slot_d = slot_q + 4'd1;
                        end
                    end
                end
                StWait: begin
                    if (bus.task_complete) begin
                        av_d = 1'b0;
                        if (last_slot) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            slot_d  = 4'd0;
                        end else begin
                            slot_d  = slot_q + 4'd1;
                            state_d = StDispatch;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            slot_q  <= 4'd0;
            unit_q  <= UnitNone;
            pick_q  <= '0;
            place_q <= '0;
            av_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ErrNone;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            unit_q  <= unit_d;
            pick_q  <= pick_d;
            place_q <= place_d;
            av_q    <= av_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.pick_node    = pick_q;
    assign bus.place_node   = place_q;
    assign bus.slot         = slot_q;
    assign bus.action_valid = av_q;
    assign bus.busy         = busy_q;
    assign bus.seq_done     = done_q;
    assign bus.msg_error    = err_q;
    assign bus.err_code     = code_q;

endmodule
